// File: rtl/m6502_pkg.sv
// -----------------------------------------------------------------------------
// m6502_pkg
//
// Definitions shared by the M6502 instruction sequencer and the decode logic.
//   - Sequencer state encoding (FETCH / EXEC).
//   - Width of the one-hot timing vector (t1..t8).
//   - Opcode loaded on reset (NOP).
//   - Indices into the decoder's enable vector, including TIMING_RESET, the
//     enable that tells the sequencer the current step is the last one.
//   - step_to_timing(): maps an execute step number to its one-hot vector.
// -----------------------------------------------------------------------------
package m6502_pkg;

    // Sequencer states. The execute step number is held separately.
    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_EXEC  = 1'b1;

    // One-hot timing vector width: t1..t8.
    localparam int TIMING_W = 8;

    // Width of the execute step counter (0 = no step, 1..8 = t1..t8).
    localparam int STEP_W = 4;

    // Opcode presented to the decoder after reset.
    localparam logic [7:0] NOP_OPCODE = 8'hEA;

    // Decoder enable-vector indices.
    localparam int EN_COUNT     = 8;
    localparam int TIMING_RESET = 0;
    localparam int PC_INC       = 1;
    localparam int PC_LOAD      = 2;
    localparam int ADDR_LO_LOAD = 3;
    localparam int ADDR_HI_LOAD = 4;
    localparam int ACC_LOAD     = 5;
    localparam int MEM_WRITE    = 6;
    localparam int FLAGS_LOAD   = 7;

    // Step n (1..TIMING_W) maps to bit n-1; step 0 (fetch) maps to all-zero.
    function automatic logic [TIMING_W-1:0] step_to_timing(input logic [STEP_W-1:0] n);
        logic [TIMING_W-1:0] t;
        t = '0;
        for (int i = 0; i < TIMING_W; i++) begin
            if (n == STEP_W'(i + 1)) begin
                t[i] = 1'b1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/seq_perf_counter.sv
// -----------------------------------------------------------------------------
// seq_perf_counter
//
// 32-bit event counter with synchronous active-low clear. Wraps modulo 2^32.
//
// Ports:
//   clock    in   rising-edge clock
//   clear_n  in   synchronous clear, active low; wins over inc
//   inc      in   add one on this edge
//   count    out  current count
// -----------------------------------------------------------------------------
module seq_perf_counter (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            count <= 32'h0;
        end else if (inc) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// -----------------------------------------------------------------------------
// timing_sequencer
//
// Instruction cycle sequencer for the M6502 core. Holds the opcode register and
// the one-hot timing vector consumed by the decoder, and ends each instruction
// when the decoder returns its TIMING_RESET enable. An instruction that is
// still running at step MAX_STEPS is trapped: the sequencer returns to fetch,
// keeps the offending opcode and flags `illegal` for that fetch cycle.
//
// Parameters:
//   MAX_STEPS     last legal execute step (1..8)
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   synchronous reset, active low
//   ready         in   memory ready; low freezes all sequencer state
//   timing_reset  in   decoder TIMING_RESET enable: current step is the last
//   data_in       in   memory read data (opcode byte during fetch)
//   timing        out  one-hot t1..t8, zero during fetch
//   opcode        out  registered current opcode
//   sync          out  high during the fetch cycle
//   illegal       out  high in the fetch cycle following a timeout trap
//   cycle_count   out  edges with ready high since reset
//   instr_count   out  opcode fetches completed since reset
//
// Build option:
//   SEQ_PERF_COUNT_EN  when defined, cycle_count/instr_count are live counters;
//                      otherwise both are tied to zero and no flops exist.
// -----------------------------------------------------------------------------
module timing_sequencer
    import m6502_pkg::*;
#(
    parameter int MAX_STEPS = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready,
    input  logic        timing_reset,
    input  logic [7:0]  data_in,
    output logic [7:0]  timing,
    output logic [7:0]  opcode,
    output logic        sync,
    output logic        illegal,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS);

    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [STEP_W-1:0]   step_q;
    logic [STEP_W-1:0]   step_d;
    logic [TIMING_W-1:0] timing_q;
    logic [7:0]          opcode_q;
    logic [7:0]          opcode_d;
    logic                trap_q;
    logic                trap_d;

    // Next-state logic. With ready low everything holds, fetch included.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        opcode_d = opcode_q;
        trap_d   = trap_q;
        if (ready) begin
            if (state_q == ST_FETCH) begin
                state_d  = ST_EXEC;
                step_d   = STEP_W'(1);
                opcode_d = data_in;
                trap_d   = 1'b0;
            end else if (timing_reset) begin
                // Normal end of instruction; takes priority over the timeout.
                state_d = ST_FETCH;
                step_d  = '0;
            end else if (step_q < LAST_STEP) begin
                step_d = step_q + STEP_W'(1);
            end else begin
                // Runaway opcode: back to fetch, keep opcode for inspection.
                state_d = ST_FETCH;
                step_d  = '0;
                trap_d  = 1'b1;
            end
        end
    end

    // Timing is registered from the next step so the decoder sees a clean
    // one-hot vector for the whole cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            step_q   <= '0;
            timing_q <= '0;
            opcode_q <= NOP_OPCODE;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            timing_q <= step_to_timing(step_d);
            opcode_q <= opcode_d;
            trap_q   <= trap_d;
        end
    end

    assign timing  = timing_q;
    assign opcode  = opcode_q;
    assign sync    = (state_q == ST_FETCH);
    assign illegal = trap_q & sync;

`ifdef SEQ_PERF_COUNT_EN
    logic fetch_done;

    assign fetch_done = ready && (state_q == ST_FETCH);

    seq_perf_counter u_cycle_counter (
        .clock   (clock),
        .clear_n (reset),
        .inc     (ready),
        .count   (cycle_count)
    );

    seq_perf_counter u_instr_counter (
        .clock   (clock),
        .clear_n (reset),
        .inc     (fetch_done),
        .count   (instr_count)
    );
`else
    assign cycle_count = 32'h0;
    assign instr_count = 32'h0;
`endif

endmodule

// File: tb/tb_timing_sequencer.sv
// -----------------------------------------------------------------------------
// tb_timing_sequencer
//
// Self-checking bench for timing_sequencer (MAX_STEPS = 6). A behavioural
// model tracks the instruction in progress as a plain step number and computes
// every expected output from it; directed scenarios additionally compare
// against literal sequences.
// -----------------------------------------------------------------------------
module tb_timing_sequencer;

    localparam int MAX = 6;

    logic        clock;
    logic        reset;
    logic        ready;
    logic        timing_reset;
    logic [7:0]  data_in;
    logic [7:0]  timing;
    logic [7:0]  opcode;
    logic        sync;
    logic        illegal;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    // Reference model: step 0 is fetch, 1..MAX are execute steps.
    int          m_step;
    logic [7:0]  m_op;
    logic        m_trap;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;

    timing_sequencer #(.MAX_STEPS(MAX)) dut (
        .clock        (clock),
        .reset        (reset),
        .ready        (ready),
        .timing_reset (timing_reset),
        .data_in      (data_in),
        .timing       (timing),
        .opcode       (opcode),
        .sync         (sync),
        .illegal      (illegal),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] exp_timing();
        logic [7:0] v;
        v = 8'h00;
        if (m_step > 0) v = 8'(1 << (m_step - 1));
        return v;
    endfunction

    function automatic logic [31:0] exp_cyc();
`ifdef SEQ_PERF_COUNT_EN
        return m_cyc;
`else
        return 32'h0;
`endif
    endfunction

    function automatic logic [31:0] exp_ins();
`ifdef SEQ_PERF_COUNT_EN
        return m_ins;
`else
        return 32'h0;
`endif
    endfunction

    // Apply inputs, take one rising edge, advance the model, settle 1 time unit.
    task automatic tick(input logic r, input logic rdy, input logic tr, input logic [7:0] d);
        reset = r; ready = rdy; timing_reset = tr; data_in = d;
        @(posedge clock);
        if (!r) begin
            m_step = 0; m_op = 8'hEA; m_trap = 1'b0; m_cyc = 0; m_ins = 0;
        end else if (rdy) begin
            m_cyc = m_cyc + 1;
            if (m_step == 0) begin
                m_op = d; m_step = 1; m_trap = 1'b0; m_ins = m_ins + 1;
            end else if (tr) begin
                m_step = 0;
            end else if (m_step < MAX) begin
                m_step = m_step + 1;
            end else begin
                m_step = 0; m_trap = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            checks++;
            if (timing !== 8'h00 || sync !== 1'b1 || opcode !== 8'hEA || illegal !== 1'b0 ||
                cycle_count !== 32'h0 || instr_count !== 32'h0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: timing=%h sync=%b opcode=%h illegal=%b cc=%0d ic=%0d, want 00 1 ea 0 0 0",
                         i, timing, sync, opcode, illegal, cycle_count, instr_count);
            end
        end
        // Reset released, ready low: still in fetch.
        tick(1'b1, 1'b0, 1'b1, 8'h55);
        checks++;
        if (sync !== 1'b1 || timing !== 8'h00 || opcode !== 8'hEA) begin
            errors++;
            $display("FAIL reset_release: sync=%b timing=%h opcode=%h, want 1 00 ea", sync, timing, opcode);
        end
    endtask

    task automatic test_nop_stream();
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b1, (m_step == 1), 8'hEA);
            checks++;
            if (timing !== ((k % 2 == 1) ? 8'h01 : 8'h00) || sync !== ((k % 2 == 1) ? 1'b0 : 1'b1) ||
                timing !== exp_timing() || opcode !== 8'hEA) begin
                errors++;
                $display("FAIL nop_stream edge%0d: timing=%h sync=%b opcode=%h, model timing=%h",
                         k, timing, sync, opcode, exp_timing());
            end
        end
        checks++;
        if (instr_count !== exp_ins() || cycle_count !== exp_cyc()) begin
            errors++;
            $display("FAIL nop_count: instr_count=%0d cycle_count=%0d, want %0d %0d",
                     instr_count, cycle_count, exp_ins(), exp_cyc());
        end
`ifdef SEQ_PERF_COUNT_EN
        checks++;
        if (instr_count !== 32'd4) begin
            errors++;
            $display("FAIL nop_instr4: instr_count=%0d want 4", instr_count);
        end
`endif
    endtask

    task automatic test_lda_sta();
        logic [7:0] seq [10];
        seq = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h00};
        checks++;
        if (timing !== seq[0] || sync !== 1'b1) begin
            errors++;
            $display("FAIL lda_sta_start: timing=%h sync=%b want 00 1", timing, sync);
        end
        for (int k = 1; k < 10; k++) begin
            tick(1'b1, 1'b1,
                 (m_step == 2 && m_op == 8'hA9) || (m_step == 5 && m_op == 8'h8D),
                 (k == 1) ? 8'hA9 : ((k == 4) ? 8'h8D : 8'($urandom)));
            checks++;
            if (timing !== seq[k] || timing !== exp_timing() || opcode !== m_op) begin
                errors++;
                $display("FAIL lda_sta step%0d: timing=%h opcode=%h want %h %h", k, timing, opcode, seq[k], m_op);
            end
            if (k == 1 || k == 4) begin
                checks++;
                if (opcode !== ((k == 1) ? 8'hA9 : 8'h8D)) begin
                    errors++;
                    $display("FAIL lda_sta_opcode%0d: opcode=%h want %h", k, opcode, (k == 1) ? 8'hA9 : 8'h8D);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] frozen;
        tick(1'b1, 1'b1, 1'b0, 8'h8D);
        tick(1'b1, 1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b1, 1'b0, 8'h00);
        checks++;
        if (timing !== 8'h04 || opcode !== 8'h8D) begin
            errors++;
            $display("FAIL stall_t3: timing=%h opcode=%h want 04 8d", timing, opcode);
        end
        frozen = cycle_count;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'($urandom), 8'($urandom));
            checks++;
            if (timing !== 8'h04 || cycle_count !== frozen || cycle_count !== exp_cyc() || opcode !== 8'h8D) begin
                errors++;
                $display("FAIL stall_hold%0d: timing=%h cc=%0d opcode=%h want 04 %0d 8d",
                         i, timing, cycle_count, opcode, frozen);
            end
        end
        tick(1'b1, 1'b1, 1'b0, 8'h00);
        checks++;
        if (timing !== 8'h08 || timing !== exp_timing() || cycle_count !== exp_cyc()) begin
            errors++;
            $display("FAIL stall_resume: timing=%h cc=%0d want 08 %0d", timing, cycle_count, exp_cyc());
        end
        tick(1'b1, 1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b1, 1'b1, 8'h00);
        checks++;
        if (sync !== 1'b1 || timing !== 8'h00) begin
            errors++;
            $display("FAIL stall_end: sync=%b timing=%h want 1 00", sync, timing);
        end
    endtask

    task automatic test_trap();
        for (int n = 1; n <= MAX; n++) begin
            tick(1'b1, 1'b1, 1'b0, (n == 1) ? 8'h02 : 8'($urandom));
            checks++;
            if (timing !== 8'(1 << (n - 1)) || illegal !== 1'b0 || opcode !== 8'h02) begin
                errors++;
                $display("FAIL trap_step%0d: timing=%h illegal=%b opcode=%h", n, timing, illegal, opcode);
            end
        end
        tick(1'b1, 1'b1, 1'b0, 8'h11);
        checks++;
        if (sync !== 1'b1 || timing !== 8'h00 || illegal !== 1'b1 || opcode !== 8'h02) begin
            errors++;
            $display("FAIL trap_fetch: sync=%b timing=%h illegal=%b opcode=%h want 1 00 1 02",
                     sync, timing, illegal, opcode);
        end
        tick(1'b1, 1'b1, 1'b1, 8'hEA);
        checks++;
        if (illegal !== 1'b0 || opcode !== 8'hEA || timing !== 8'h01) begin
            errors++;
            $display("FAIL trap_clear: illegal=%b opcode=%h timing=%h want 0 ea 01", illegal, opcode, timing);
        end
        tick(1'b1, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 1'b1, 1'b0, 8'hAD);
        tick(1'b1, 1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b1, 1'b0, 8'h00);
        checks++;
        if (timing !== 8'h04 || opcode !== 8'hAD) begin
            errors++;
            $display("FAIL midreset_pre: timing=%h opcode=%h want 04 ad", timing, opcode);
        end
        tick(1'b0, 1'b1, 1'b1, 8'h77);
        checks++;
        if (timing !== 8'h00 || opcode !== 8'hEA || sync !== 1'b1 || illegal !== 1'b0 ||
            cycle_count !== 32'h0 || instr_count !== 32'h0) begin
            errors++;
            $display("FAIL midreset: timing=%h opcode=%h sync=%b illegal=%b cc=%0d ic=%0d want 00 ea 1 0 0 0",
                     timing, opcode, sync, illegal, cycle_count, instr_count);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                 8'($urandom));
            checks++;
            if (timing !== exp_timing() || opcode !== m_op || sync !== (m_step == 0) ||
                illegal !== (m_trap && m_step == 0) || cycle_count !== exp_cyc() ||
                instr_count !== exp_ins()) begin
                errors++;
                if (bad < 10) begin
                    $display("FAIL random cyc%0d: timing=%h opcode=%h sync=%b illegal=%b cc=%0d ic=%0d want %h %h %b %b %0d %0d",
                             i, timing, opcode, sync, illegal, cycle_count, instr_count,
                             exp_timing(), m_op, (m_step == 0), (m_trap && m_step == 0), exp_cyc(), exp_ins());
                end
                bad++;
            end
        end
    endtask

    initial begin
        reset = 1'b0; ready = 1'b0; timing_reset = 1'b0; data_in = 8'h00;
        m_step = 0; m_op = 8'hEA; m_trap = 1'b0; m_cyc = 0; m_ins = 0;
        test_reset();
        test_nop_stream();
        test_lda_sta();
        test_stall();
        test_trap();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
